seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Output-side display driver for the board-level TOP: the counterpart to the stimulus-side view of SevenSegAn/SevenSegCat. Takes a 32-bit value from the processor datapath, double-buffers it, and time-multiplexes eight hex digits onto the shared active-low anode/cathode pins. It replaces ad-hoc combinational display logic with a refresh timer, ghosting dead-time, leading-zero suppression and a frame-synchronous update.

## Interface

- SCAN_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal minimum 4
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < SCAN_DIV
- CLK  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low: Reset = 0 at a rising edge clears all state
- Value  in  32  hex value; digit 0 = Value[3:0], digit 7 = Value[31:28]
- Load  in  1  capture strobe; Value sampled into shadow register when high
- BlankLeading  in  1  1 = suppress leading zero digits
- DigitEn  in  8  per-digit enable; 0 forces that anode off
- SevenSegAn  out  8  active-low anode select, bit i = digit i
- SevenSegCat  out  7  active-low segments, {g,f,e,d,c,b,a}
- FrameDone  out  1  one-cycle pulse at each frame boundary

## Operation

- Reset values: SevenSegAn = 8'hFF, SevenSegCat = 7'h7F, FrameDone = 0, slot counter = 0, digit index = 0, shadow = 0, display buffer = 0.
- Slot counter counts 0..SCAN_DIV-1 and wraps; on wrap, digit index advances 0→1→…→7→0.
- Frame boundary = counter wrap while index = 7. On that cycle: index → 0, display buffer ← shadow, FrameDone = 1.
- Load: shadow ← Value on the next edge. Load coincident with a frame boundary: display buffer takes Value directly (bypass), shadow also updated.
- Digit i is dark (anode high) if: counter < BLANK_CYCLES, or DigitEn[i] = 0, or leading-blanked.
- Leading-blanked: BlankLeading = 1 and buffer nibbles i..7 are all zero; digit 0 never leading-blanked.
- When any digit is dark, SevenSegCat = 7'h7F; otherwise the active-low hex pattern of buffer nibble i.
- Hex patterns: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, A = 7'h08, F = 7'h0E (full 16-entry table in package).
- Reset asserted mid-frame: all outputs return to reset values on that edge; scanning restarts at digit 0, counter 0, display shows 0 after the first boundary.

## Timing

- All outputs registered; pins reflect (counter, index, buffer) one cycle later.
- Digit slot = SCAN_DIV cycles; frame = 8 × SCAN_DIV cycles.
- Load to visible: at most 8 × SCAN_DIV + 1 cycles (next boundary plus output register).
- FrameDone asserted exactly 1 cycle every 8 × SCAN_DIV cycles; first pulse 8 × SCAN_DIV cycles after Reset deasserts.
- Anode active window per slot: SCAN_DIV − BLANK_CYCLES cycles; never two anodes low in the same cycle.
- BlankLeading and DigitEn are not buffered; they take effect on the next output update.

## Structure

- Package seven_seg_pkg: NUM_DIGITS = 8, SEG_OFF = 7'h7F, AN_OFF = 8'hFF, 16-entry hex-to-segment constant table, segment bit-order constants.
- Sub-module seven_seg_hex_decode: combinational nibble → active-low cathode pattern using the package table.
- Top of block: slot counter, digit index, shadow/display registers, blank logic, output registers.

## Test plan

Run with SCAN_DIV = 8, BLANK_CYCLES = 2.

- Reset held low 3 cycles, mid-frame → SevenSegAn = FF, SevenSegCat = 7F, FrameDone = 0; first FrameDone 64 cycles after release.
- Load 32'h89AB_CDEF, observe two frames → first frame all zeros; second frame digit 0 = F (0E), digit 1 = E, …, digit 7 = 8 (00); anode i low only for cycles 2..7 of slot i.
- Load 32'h0000_0010 with BlankLeading = 1 → digits 7..2 dark, digit 1 = 79, digit 0 = 40; BlankLeading = 0 → digits 7..2 show 40.
- Value 0, BlankLeading = 1 → digit 0 still shows 40, others dark.
- DigitEn = 8'b1111_0000 → anodes 0..3 never low, cathodes 7F during slots 0..3.
- Load on the exact boundary cycle with 32'h1111_1111 → next frame shows 79 on all digits; Load one cycle after boundary → shown one frame later.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared widths, off-state constants, segment bit order and the
// hex-to-segment table for the 8-digit multiplexed seven-segment display.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;

  typedef logic [SEG_W-1:0]      seg_t;
  typedef logic [NUM_DIGITS-1:0] an_t;

  // Pins are active-low, so "off" is all ones.
  localparam seg_t SEG_OFF = 7'h7F;
  localparam an_t  AN_OFF  = 8'hFF;

  // Cathode bit positions within seg_t: {g,f,e,d,c,b,a}.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low glyphs for 0..F (lowercase b and d to stay distinct from 8 and 0).
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Active-low one-hot anode select for a digit index.
  function automatic an_t anode_sel(input logic [IDX_W-1:0] idx);
    return ~(an_t'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: combinational nibble to active-low cathode pattern.
//   i_nibble : hex digit 0..F
//   o_seg_c  : active-low segments {g,f,e,d,c,b,a}
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output seg_t             o_seg_c
);

  assign o_seg_c = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: double-buffered 8-digit hex display scanner with
// per-slot ghosting dead-time, leading-zero suppression and frame-synchronous
// buffer update.
//   CLK          : system clock, rising edge
//   Reset        : synchronous active-low reset
//   Value        : 32-bit value, digit 0 = Value[3:0]
//   Load         : capture Value into the shadow register
//   BlankLeading : suppress leading zero digits (digit 0 always shown)
//   DigitEn      : per-digit enable, 0 forces that anode off
//   SevenSegAn   : active-low anode select, bit i = digit i
//   SevenSegCat  : active-low segments {g,f,e,d,c,b,a}
//   FrameDone    : one-cycle pulse at each frame boundary
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [VAL_W-1:0]      Value,
  input  logic                  Load,
  input  logic                  BlankLeading,
  input  logic [NUM_DIGITS-1:0] DigitEn,
  output logic [NUM_DIGITS-1:0] SevenSegAn,
  output logic [SEG_W-1:0]      SevenSegCat,
  output logic                  FrameDone
);

  localparam int unsigned     CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [VAL_W-1:0] r_shadow;
  logic [VAL_W-1:0] r_buf;
  an_t              r_an;
  seg_t             r_cat;
  logic             r_frame_done;

  logic             w_slot_end;
  logic             w_boundary;
  logic [IDX_W+1:0] w_shamt;
  logic [VAL_W-1:0] w_upper;
  logic             w_lead_blank;
  logic             w_dark;
  seg_t             w_seg;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Nibbles idx..7 of the buffer; the low nibble is the digit being scanned.
  assign w_shamt      = {r_idx, 2'b00};
  assign w_upper      = r_buf >> w_shamt;
  assign w_lead_blank = BlankLeading && (r_idx != '0) && (w_upper == '0);
  assign w_dark       = (r_cnt < CNT_BLANK) || !DigitEn[r_idx] || w_lead_blank;

  seven_seg_hex_decode u_hex_decode (
    .i_nibble (w_upper[NIB_W-1:0]),
    .o_seg_c  (w_seg)
  );

  // Scan timing, buffering and registered pin drive.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_buf        <= '0;
      r_an         <= AN_OFF;
      r_cat        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
      if (w_slot_end) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (Load) begin
        r_shadow <= Value;
      end
      // A load on the boundary cycle bypasses the shadow so it is not lost a frame.
      if (w_boundary) begin
        r_buf <= Load ? Value : r_shadow;
      end
      r_frame_done <= w_boundary;
      r_an         <= w_dark ? AN_OFF : anode_sel(r_idx);
      r_cat        <= w_dark ? SEG_OFF : w_seg;
    end
  end

  assign SevenSegAn  = r_an;
  assign SevenSegCat = r_cat;
  assign FrameDone   = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed self-checking bench, SCAN_DIV = 8, BLANK_CYCLES = 2.
module tb_seven_seg_scanner;

  logic        CLK;
  logic        Reset;
  logic [31:0] Value;
  logic        Load;
  logic        BlankLeading;
  logic [7:0]  DigitEn;
  logic [7:0]  SevenSegAn;
  logic [6:0]  SevenSegCat;
  logic        FrameDone;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_scanner #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Value        (Value),
    .Load         (Load),
    .BlankLeading (BlankLeading),
    .DigitEn      (DigitEn),
    .SevenSegAn   (SevenSegAn),
    .SevenSegCat  (SevenSegCat),
    .FrameDone    (FrameDone)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called on the negedge where FrameDone is high; checks the following frame
  // sample by sample. exp_cat entry 7F marks a digit expected dark.
  // With ld_end set, Load/ld_val are driven so they hit the next boundary edge.
  task automatic check_frame(input logic [6:0] exp_cat [8], input bit ld_end,
                             input logic [31:0] ld_val);
    logic [7:0] one;
    logic [7:0] e_an;
    logic [6:0] e_cat;
    bit         dark;
    one = 8'h01;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 8; c++) begin
        @(posedge CLK);
        @(negedge CLK);
        Load = 1'b0;
        dark  = (c < 2) || (exp_cat[s] == 7'h7F);
        e_an  = dark ? 8'hFF : ~(one << s);
        e_cat = dark ? 7'h7F : exp_cat[s];
        chk($sformatf("an s%0d c%0d", s, c), 32'(SevenSegAn), 32'(e_an));
        chk($sformatf("cat s%0d c%0d", s, c), 32'(SevenSegCat), 32'(e_cat));
        chk($sformatf("fd s%0d c%0d", s, c), 32'(FrameDone), 32'((s == 7 && c == 7) ? 1 : 0));
        if (ld_end && s == 7 && c == 6) begin
          Load  = 1'b1;
          Value = ld_val;
        end
      end
    end
  endtask

  logic [6:0] f_zero   [8];
  logic [6:0] f_full   [8];
  logic [6:0] f_10_bl  [8];
  logic [6:0] f_10_nb  [8];
  logic [6:0] f_0_bl   [8];
  logic [6:0] f_en_z   [8];
  logic [6:0] f_en_f   [8];
  logic [6:0] f_ones   [8];
  logic [6:0] f_eights [8];

  initial begin
    int n;
    f_zero   = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    f_full   = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    f_10_bl  = '{7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    f_10_nb  = '{7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    f_0_bl   = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    f_en_z   = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
    f_en_f   = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h08, 7'h10, 7'h00};
    f_ones   = '{7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    f_eights = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    Reset = 1'b0; Value = '0; Load = 1'b0; BlankLeading = 1'b0; DigitEn = 8'hFF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;

    // Run into slot 2 with a pending shadow load, then reset mid-frame.
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      Load = (k == 5);
      if (k == 5) Value = 32'h1234_5678;
    end
    chk("pre_rst an", 32'(SevenSegAn), 32'h0000_00FB);
    chk("pre_rst cat", 32'(SevenSegCat), 32'h0000_0040);

    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("rst an %0d", k), 32'(SevenSegAn), 32'h0000_00FF);
      chk($sformatf("rst cat %0d", k), 32'(SevenSegCat), 32'h0000_007F);
      chk($sformatf("rst fd %0d", k), 32'(FrameDone), 32'h0);
    end
    Reset = 1'b1;

    n = 0;
    while (!FrameDone && n < 200) begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
    end
    chk("first_fd cycles", 32'(n), 32'd64);

    // Load after the boundary: one frame of old (zero) contents, then the new value.
    Value = 32'h89AB_CDEF; Load = 1'b1;
    check_frame(f_zero, 1'b0, '0);
    check_frame(f_full, 1'b0, '0);

    Value = 32'h0000_0010; Load = 1'b1; BlankLeading = 1'b1;
    check_frame(f_full, 1'b0, '0);
    check_frame(f_10_bl, 1'b0, '0);
    BlankLeading = 1'b0;
    check_frame(f_10_nb, 1'b0, '0);

    Value = 32'h0000_0000; Load = 1'b1; BlankLeading = 1'b1;
    check_frame(f_10_bl, 1'b0, '0);
    check_frame(f_0_bl, 1'b0, '0);

    BlankLeading = 1'b0; DigitEn = 8'b1111_0000;
    Value = 32'h89AB_CDEF; Load = 1'b1;
    check_frame(f_en_z, 1'b0, '0);
    check_frame(f_en_f, 1'b0, '0);
    DigitEn = 8'hFF;

    // Load exactly on the boundary cycle is visible in the very next frame.
    check_frame(f_full, 1'b1, 32'h1111_1111);
    check_frame(f_ones, 1'b0, '0);

    // Load one cycle after the boundary waits a full frame.
    Value = 32'h8888_8888; Load = 1'b1;
    check_frame(f_ones, 1'b0, '0);
    check_frame(f_eights, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
